// File: rtl/seg_scan_decoder.sv
// Display-bus monitor: samples the scanned anode/segment bus, debounces each digit,
// decodes glyphs back to nibbles and publishes a coherent 4-digit frame.
module seg_scan_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 262144,
    parameter int CW             = 19
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        en,
    input  logic [3:0]  anode,
    input  logic [6:0]  seg,
    output logic [15:0] digits,
    output logic [3:0]  blank_mask,
    output logic        frame_valid,
    output logic        err_invalid,
    output logic        err_timeout
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [SW-1:0] STAB_SAT  = SW'(STABLE_CYCLES);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);

    logic [10:0]   sample_q;
    logic [SW-1:0] stab_cnt;
    logic [3:0]    seen;
    logic [CW-1:0] to_cnt;
    logic [15:0]   shadow;
    logic [3:0]    shadow_blank;

    logic [3:0] sel;
    logic       one_hot;
    logic [1:0] dig_idx;
    logic       accept;
    logic       glyph_ok;
    logic       glyph_blank;
    logic [3:0] glyph_nib;
    logic       frame_done;
    logic       timed_out;

    assign sel        = ~sample_q[10:7];
    assign one_hot    = (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
    // stab_cnt saturates one above STAB_LAST so accept is a single-cycle event per hold
    assign accept     = (stab_cnt == STAB_LAST) && one_hot;
    assign frame_done = (seen == 4'b1111);
    assign timed_out  = !frame_done && (seen != 4'd0) && (to_cnt == TO_LAST);

    always_comb begin
        dig_idx = 2'd0;
        case (sel)
            4'b0001: dig_idx = 2'd0;
            4'b0010: dig_idx = 2'd1;
            4'b0100: dig_idx = 2'd2;
            4'b1000: dig_idx = 2'd3;
            default: dig_idx = 2'd0;
        endcase
    end

    always_comb begin
        glyph_ok    = 1'b1;
        glyph_blank = 1'b0;
        glyph_nib   = 4'hF;
        case (sample_q[6:0])
            7'b0111111: glyph_nib = 4'd0;
            7'b0000110: glyph_nib = 4'd1;
            7'b1011011: glyph_nib = 4'd2;
            7'b1001111: glyph_nib = 4'd3;
            7'b1100110: glyph_nib = 4'd4;
            7'b1101101: glyph_nib = 4'd5;
            7'b1111101: glyph_nib = 4'd6;
            7'b0000111: glyph_nib = 4'd7;
            7'b1111111: glyph_nib = 4'd8;
            7'b1101111: glyph_nib = 4'd9;
            7'b0000000: glyph_blank = 1'b1;
            default:    glyph_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sample_q     <= '0;
            stab_cnt     <= '0;
            seen         <= '0;
            to_cnt       <= '0;
            shadow       <= '0;
            shadow_blank <= '0;
            digits       <= '0;
            blank_mask   <= '0;
            frame_valid  <= 1'b0;
            err_invalid  <= 1'b0;
            err_timeout  <= 1'b0;
        end else if (!en) begin
            sample_q    <= '0;
            stab_cnt    <= '0;
            seen        <= '0;
            to_cnt      <= '0;
            frame_valid <= 1'b0;
            err_invalid <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            sample_q <= {anode, seg};
            if ({anode, seg} != sample_q) begin
                stab_cnt <= '0;
            end else if (stab_cnt != STAB_SAT) begin
                stab_cnt <= stab_cnt + SW'(1);
            end

            frame_valid <= frame_done;
            err_timeout <= timed_out;
            err_invalid <= accept && !glyph_ok;

            if (frame_done) begin
                digits     <= shadow;
                blank_mask <= shadow_blank;
            end

            if (accept && glyph_ok) begin
                shadow[{dig_idx, 2'b00} +: 4] <= glyph_nib;
                shadow_blank[dig_idx]         <= glyph_blank;
            end

            // an accept landing on a completion or timeout edge is dropped with the frame
            if (frame_done || timed_out) begin
                seen <= '0;
            end else if (accept && glyph_ok) begin
                seen[dig_idx] <= 1'b1;
            end

            if ((seen == 4'd0) || timed_out) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + CW'(1);
            end
        end
    end

endmodule
